// File: rtl/rom_load_pkg.sv
// Shared types and defaults for the ROM byte-source arbiter that feeds Game_Loader.
package rom_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_XFER,
        ST_DONE
    } state_t;

    localparam int BYTE_CNT_W     = 24;
    localparam int DEF_GAP        = 4;
    localparam int DEF_RST_CYCLES = 8;

    // Byte counter sticks at all-ones instead of wrapping.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/prio_onehot.sv
// Combinational lowest-index-first one-hot picker; bit 0 has highest priority.
module prio_onehot #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot
);

    logic found;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_load_arbiter.sv
// Arbitrates NSRC ROM byte sources onto the single Game_Loader byte port,
// one granted source per session, with a loader reset pulse and byte pacing.
//
// state | meaning
// IDLE  | no session; first requester (lowest index) is granted
// PREP  | loader_reset held for RST_CYCLES; abort if the owner drops src_req
// XFER  | bytes accepted from the owner, spaced at least GAP cycles apart
// DONE  | one-cycle tail; grant cleared, then back to IDLE
module rom_load_arbiter
    import rom_load_pkg::*;
#(
    parameter int NSRC       = 2,
    parameter int GAP        = DEF_GAP,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC-1:0]       src_req,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [8*NSRC-1:0]     src_data,
    output logic [NSRC-1:0]       src_ready,
    output logic [NSRC-1:0]       grant,
    output logic                  loader_reset,
    output logic                  downloading,
    output logic [7:0]            odata,
    output logic                  odata_clk,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic [RST_W-1:0] rst_cnt;
    logic [NSRC-1:0]  pick;
    logic [7:0]       sel_data;
    logic             owner_req;
    logic             accept;

    prio_onehot #(.N(NSRC)) u_pick (
        .req    (src_req),
        .onehot (pick)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) sel_data = sel_data | src_data[8*i +: 8];
        end
    end

    // Only the owner ever sees ready, so other sources cannot stall into the loader.
    assign src_ready = grant & {NSRC{(state == ST_XFER) && (gap_cnt == '0)}};
    assign owner_req = |(src_req & grant);
    assign accept    = |(src_valid & src_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            gap_cnt      <= '0;
            rst_cnt      <= '0;
            grant        <= '0;
            loader_reset <= 1'b0;
            downloading  <= 1'b0;
            odata        <= '0;
            odata_clk    <= 1'b0;
            byte_count   <= '0;
        end else begin
            odata_clk <= 1'b0;
            if (accept) begin
                odata      <= sel_data;
                odata_clk  <= 1'b1;
                gap_cnt    <= GAP_LOAD;
                byte_count <= sat_inc(byte_count);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (|src_req) begin
                        grant        <= pick;
                        byte_count   <= '0;
                        rst_cnt      <= RST_LOAD;
                        loader_reset <= 1'b1;
                        downloading  <= 1'b1;
                        state        <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (!owner_req) begin
                        loader_reset <= 1'b0;
                        downloading  <= 1'b0;
                        state        <= ST_DONE;
                    end else if (rst_cnt == '0) begin
                        loader_reset <= 1'b0;
                        gap_cnt      <= '0;
                        state        <= ST_XFER;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                // A byte accepted on the same edge the owner lets go still gets strobed.
                ST_XFER: begin
                    if (!owner_req) begin
                        downloading <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Bench for rom_load_arbiter: two instances (GAP=4 and GAP=1) checked every cycle
// against a session-level timing model, plus directed scenarios and random traffic.
module tb_rom_load_arbiter;

    localparam int RST   = 8;
    localparam int GAP_A = 4;
    localparam int GAP_B = 1;

    localparam int P_IDLE = 0;
    localparam int P_PREP = 1;
    localparam int P_XFER = 2;
    localparam int P_DONE = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req   [2];
    logic [1:0]  valid [2];
    logic [15:0] data  [2];
    logic [1:0]  ready [2];
    logic [1:0]  grant [2];
    logic        lrst  [2];
    logic        dl    [2];
    logic        oclk  [2];
    logic [7:0]  odata [2];
    logic [23:0] cnt   [2];

    rom_load_arbiter #(.NSRC(2), .GAP(GAP_A), .RST_CYCLES(RST)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .src_req(req[0]), .src_valid(valid[0]), .src_data(data[0]),
        .src_ready(ready[0]), .grant(grant[0]), .loader_reset(lrst[0]),
        .downloading(dl[0]), .odata(odata[0]), .odata_clk(oclk[0]),
        .byte_count(cnt[0])
    );

    rom_load_arbiter #(.NSRC(2), .GAP(GAP_B), .RST_CYCLES(RST)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .src_req(req[1]), .src_valid(valid[1]), .src_data(data[1]),
        .src_ready(ready[1]), .grant(grant[1]), .loader_reset(lrst[1]),
        .downloading(dl[1]), .odata(odata[1]), .odata_clk(oclk[1]),
        .byte_count(cnt[1])
    );

    // Session model: phase plus absolute edge numbers for PREP end and next legal accept.
    int          m_ph       [2];
    int          m_g        [2];
    longint      m_xfer_edge[2];
    longint      m_next_ok  [2];
    logic [1:0]  m_grant    [2];
    logic        m_lrst     [2];
    logic        m_dl       [2];
    logic        m_oclk     [2];
    logic [7:0]  m_odata    [2];
    logic [23:0] m_cnt      [2];

    longint cyc;
    int errors;
    int checks;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? GAP_A : GAP_B;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = P_IDLE; m_g[d] = 0; m_xfer_edge[d] = 0; m_next_ok[d] = 0;
            m_grant[d] = '0; m_lrst[d] = 1'b0; m_dl[d] = 1'b0; m_oclk[d] = 1'b0;
            m_odata[d] = '0; m_cnt[d] = '0;
        end
    endtask

    task automatic model_edge(input int d);
        logic acc;
        acc = (m_ph[d] == P_XFER) && (cyc >= m_next_ok[d]) && valid[d][m_g[d]];
        m_oclk[d] = 1'b0;
        if (acc) begin
            m_oclk[d]    = 1'b1;
            m_odata[d]   = data[d][8*m_g[d] +: 8];
            m_cnt[d]     = (m_cnt[d] == 24'hFFFFFF) ? m_cnt[d] : m_cnt[d] + 24'd1;
            m_next_ok[d] = cyc + gap_of(d);
        end
        case (m_ph[d])
            P_IDLE: if (req[d] != 2'b00) begin
                m_g[d]         = req[d][0] ? 0 : 1;
                m_grant[d]     = 2'b01 << m_g[d];
                m_cnt[d]       = '0;
                m_lrst[d]      = 1'b1;
                m_dl[d]        = 1'b1;
                m_xfer_edge[d] = cyc + RST;
                m_ph[d]        = P_PREP;
            end
            P_PREP: if (!req[d][m_g[d]]) begin
                m_ph[d] = P_DONE; m_lrst[d] = 1'b0; m_dl[d] = 1'b0;
            end else if (cyc == m_xfer_edge[d]) begin
                m_ph[d] = P_XFER; m_lrst[d] = 1'b0; m_next_ok[d] = cyc + 1;
            end
            P_XFER: if (!req[d][m_g[d]]) begin
                m_ph[d] = P_DONE; m_dl[d] = 1'b0;
            end
            default: begin
                m_grant[d] = '0; m_ph[d] = P_IDLE;
            end
        endcase
    endtask

    task automatic check_outputs(input int d);
        logic [1:0] er;
        string p;
        p  = (d == 0) ? "g4" : "g1";
        er = (m_ph[d] == P_XFER && cyc >= m_next_ok[d]) ? m_grant[d] : 2'b00;
        check_val({p, " grant"},        grant[d], m_grant[d]);
        check_val({p, " src_ready"},    ready[d], er);
        check_val({p, " loader_reset"}, lrst[d],  m_lrst[d]);
        check_val({p, " downloading"},  dl[d],    m_dl[d]);
        check_val({p, " odata_clk"},    oclk[d],  m_oclk[d]);
        check_val({p, " odata"},        odata[d], m_odata[d]);
        check_val({p, " byte_count"},   cnt[d],   m_cnt[d]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        #1;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic rand_drive(input int d);
        for (int i = 0; i < 2; i++) begin
            if (req[d][i]) begin
                if ($urandom_range(0, 99) < 3) req[d][i] = 1'b0;
            end else if ($urandom_range(0, 99) < 8) begin
                req[d][i] = 1'b1;
            end
            valid[d][i] = ($urandom_range(0, 99) < 60);
            data[d][8*i +: 8] = 8'($urandom);
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; valid[d] = '0; data[d] = '0;
        end
    endtask

    initial begin
        logic [7:0] bytes [4];
        int strobes, idx, nl;
        longint last;
        logic acc;
        logic [4:0] pat;

        errors = 0; checks = 0; cyc = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0);
        check_outputs(1);
        reset_n = 1'b1;
        repeat (2) cycle();

        // Single session from source 1 on the GAP=4 instance.
        bytes[0] = 8'h4E; bytes[1] = 8'h45; bytes[2] = 8'h53; bytes[3] = 8'h1A;
        req[0] = 2'b10; valid[0] = 2'b10; data[0] = {bytes[0], 8'h00};
        strobes = 0; idx = 0; nl = 0; last = -1;
        for (int n = 0; n < 80 && (strobes < 4 || dl[0]); n++) begin
            acc = valid[0][1] & ready[0][1];
            cycle();
            if (lrst[0]) nl++;
            if (oclk[0]) begin
                if (strobes < 4) check_val("s1 byte", odata[0], bytes[strobes]);
                if (last >= 0) check_val("s1 spacing", 64'(cyc - last), 64'd4);
                last = cyc;
                strobes++;
            end
            if (acc) begin
                idx++;
                if (idx < 4) data[0][15:8] = bytes[idx];
                else begin req[0] = '0; valid[0] = '0; end
            end
        end
        check_val("s1 strobes", strobes, 4);
        check_val("s1 reset_len", nl, 8);
        check_val("s1 byte_count", cnt[0], 24'd4);
        check_val("s1 grant_in_done", grant[0], 2'b10);
        cycle();
        check_val("s1 grant_cleared", grant[0], 2'b00);
        repeat (2) cycle();

        // Simultaneous requests: source 0 wins, source 1 follows after DONE.
        req[0] = 2'b11; valid[0] = 2'b11; data[0] = 16'h2211;
        cycle();
        check_val("s2 first_grant", grant[0], 2'b01);
        strobes = 0;
        for (int n = 0; n < 60 && strobes < 3; n++) begin
            cycle();
            if (oclk[0]) strobes++;
            data[0] = 16'($urandom);
        end
        check_val("s2 src0_strobes", strobes, 3);
        req[0][0] = 1'b0; valid[0][0] = 1'b0;
        for (int n = 0; n < 10 && grant[0] != 2'b10; n++) cycle();
        check_val("s2 regrant", grant[0], 2'b10);
        check_val("s2 count_restart", cnt[0], 24'd0);
        nl = lrst[0] ? 1 : 0;
        repeat (11) begin cycle(); if (lrst[0]) nl++; end
        check_val("s2 reset_len", nl, 8);
        req[0] = '0; valid[0] = '0;
        repeat (4) cycle();

        // Stall pattern on the GAP=1 instance.
        req[1] = 2'b01; valid[1] = '0;
        for (int n = 0; n < 20 && !ready[1][0]; n++) cycle();
        check_val("s3 ready", ready[1][0], 1'b1);
        pat = 5'b10011;
        for (int k = 0; k < 5; k++) begin
            valid[1][0] = pat[k];
            data[1][7:0] = 8'(8'h10 + k);
            cycle();
            check_val("s3 strobe", oclk[1], pat[k]);
            if (pat[k]) check_val("s3 byte", odata[1], 8'(8'h10 + k));
        end
        valid[1] = '0; req[1] = '0;
        cycle();
        check_val("s3 no_extra", oclk[1], 1'b0);
        check_val("s3 byte_count", cnt[1], 24'd3);
        repeat (3) cycle();

        // Last byte on the same edge the request falls.
        req[0] = 2'b01;
        for (int n = 0; n < 20 && !ready[0][0]; n++) cycle();
        valid[0] = 2'b01; data[0] = 16'h00A5; req[0] = '0;
        cycle();
        check_val("s4 downloading", dl[0], 1'b0);
        check_val("s4 strobe", oclk[0], 1'b1);
        check_val("s4 byte", odata[0], 8'hA5);
        check_val("s4 byte_count", cnt[0], 24'd1);
        valid[0] = '0;
        repeat (3) cycle();

        // Abort during PREP.
        req[0] = 2'b01; valid[0] = 2'b01;
        cycle();
        repeat (4) cycle();
        req[0] = '0;
        cycle();
        check_val("s5 abort_reset", lrst[0], 1'b0);
        check_val("s5 abort_dl", dl[0], 1'b0);
        strobes = 0;
        repeat (4) begin cycle(); if (oclk[0]) strobes++; end
        check_val("s5 abort_strobes", strobes, 0);

        // Asynchronous reset in the middle of a transfer.
        req[0] = 2'b01; valid[0] = 2'b01; data[0] = 16'h0077;
        for (int n = 0; n < 30 && !oclk[0]; n++) cycle();
        check_val("s5 xfer_reached", oclk[0], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("s5 rst_grant", grant[0], 2'b00);
        check_val("s5 rst_dl", dl[0], 1'b0);
        check_val("s5 rst_oclk", oclk[0], 1'b0);
        check_val("s5 rst_cnt", cnt[0], 24'd0);
        check_outputs(0);
        check_outputs(1);
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) cycle();

        // Byte counter saturation.
        req[0] = 2'b01; valid[0] = '0;
        repeat (2) cycle();
        force dut0.byte_count = 24'hFFFFFE;
        #1;
        release dut0.byte_count;
        m_cnt[0] = 24'hFFFFFE;
        valid[0] = 2'b01; data[0] = 16'h0031;
        strobes = 0; idx = 0;
        for (int n = 0; n < 60 && (strobes < 3 || dl[0]); n++) begin
            acc = valid[0][0] & ready[0][0];
            cycle();
            if (oclk[0]) strobes++;
            if (acc) begin
                idx++;
                data[0][7:0] = 8'(8'h31 + idx);
                if (idx == 3) begin req[0] = '0; valid[0] = '0; end
            end
        end
        check_val("s6 strobes", strobes, 3);
        check_val("s6 saturated", cnt[0], 24'hFFFFFF);
        repeat (3) cycle();

        // Random traffic on both instances against the model.
        for (int n = 0; n < 1500; n++) begin
            rand_drive(0);
            rand_drive(1);
            cycle();
        end
        idle_inputs();
        repeat (20) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
